axi_wr_arbiter: RTL and testbench

- Two-requester AXI4 write-channel arbiter. It shares a single AXI4 write port (AW/W/B) to memory between the camera capture path (m0, camera_ctrl output) and a second writer (m1, e.g. CPU/DMA).
- Round-robin grant with one transaction outstanding at a time.
- Enforces burst length on W and reports protocol errors.
- Sits between camera_ctrl and the interconnect/DDR slave, clocked by iclk.

---
 rtl/axi_wr_pkg.sv | 11 +
 rtl/axi_wr_arbiter_rr.sv | 23 ++
 rtl/axi_wr_arbiter.sv | 159 +++++++++++++++
 tb/tb_axi_wr_arbiter.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/axi_wr_pkg.sv
// Shared types and constants for the two-port AXI4 write arbiter.
package axi_wr_pkg;
  localparam int AXI_ADDR_W_DEF = 32;
  localparam int AXI_DATA_W_DEF = 32;
  localparam int AXI_ID_W_DEF   = 16;

  localparam logic [1:0] RESP_OKAY   = 2'd0;
  localparam logic [1:0] RESP_SLVERR = 2'd2;

  typedef enum logic [1:0] {IDLE, ADDR, DATA, RESP} state_e;
endpackage

// File: rtl/axi_wr_arbiter_rr.sv
// Two-way round-robin picker; pointer moves to the other side after each served burst.
module axi_rr_arb2 (
  input  logic       iclk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       update,
  input  logic       served,
  output logic       grant
);
  logic ptr_q, ptr_d;

  always_comb begin
    ptr_d = ptr_q;
    if (update) ptr_d = ~served;
  end

  always_ff @(posedge iclk) begin
    if (!rst_n) ptr_q <= 1'b0;
    else        ptr_q <= ptr_d;
  end

  assign grant = req[ptr_q] ? ptr_q : ~ptr_q;
endmodule

// File: rtl/axi_wr_arbiter.sv
// Shares one AXI4 write port between two requesters, one burst outstanding at a time.
module axi_wr_arbiter
  import axi_wr_pkg::*;
#(
  parameter int AXI4_ADDRESS_WIDTH = AXI_ADDR_W_DEF,
  parameter int AXI4_WDATA_WIDTH   = AXI_DATA_W_DEF,
  parameter int AXI4_ID_WIDTH      = AXI_ID_W_DEF
) (
  input  logic                          iclk,
  input  logic                          rst_n,
  input  logic [AXI4_ID_WIDTH-1:0]      m0_aw_id_i,
  input  logic [AXI4_ADDRESS_WIDTH-1:0] m0_aw_addr_i,
  input  logic [7:0]                    m0_aw_len_i,
  input  logic                          m0_aw_valid_i,
  output logic                          m0_aw_ready_o,
  input  logic [AXI4_WDATA_WIDTH-1:0]   m0_w_data_i,
  input  logic [AXI4_WDATA_WIDTH/8-1:0] m0_w_strb_i,
  input  logic                          m0_w_last_i,
  input  logic                          m0_w_valid_i,
  output logic                          m0_w_ready_o,
  output logic [AXI4_ID_WIDTH-1:0]      m0_b_id_o,
  output logic [1:0]                    m0_b_resp_o,
  output logic                          m0_b_valid_o,
  input  logic                          m0_b_ready_i,
  input  logic [AXI4_ID_WIDTH-1:0]      m1_aw_id_i,
  input  logic [AXI4_ADDRESS_WIDTH-1:0] m1_aw_addr_i,
  input  logic [7:0]                    m1_aw_len_i,
  input  logic                          m1_aw_valid_i,
  output logic                          m1_aw_ready_o,
  input  logic [AXI4_WDATA_WIDTH-1:0]   m1_w_data_i,
  input  logic [AXI4_WDATA_WIDTH/8-1:0] m1_w_strb_i,
  input  logic                          m1_w_last_i,
  input  logic                          m1_w_valid_i,
  output logic                          m1_w_ready_o,
  output logic [AXI4_ID_WIDTH-1:0]      m1_b_id_o,
  output logic [1:0]                    m1_b_resp_o,
  output logic                          m1_b_valid_o,
  input  logic                          m1_b_ready_i,
  output logic [AXI4_ID_WIDTH-1:0]      s_aw_id_o,
  output logic [AXI4_ADDRESS_WIDTH-1:0] s_aw_addr_o,
  output logic [7:0]                    s_aw_len_o,
  output logic                          s_aw_valid_o,
  input  logic                          s_aw_ready_i,
  output logic [AXI4_WDATA_WIDTH-1:0]   s_w_data_o,
  output logic [AXI4_WDATA_WIDTH/8-1:0] s_w_strb_o,
  output logic                          s_w_last_o,
  output logic                          s_w_valid_o,
  input  logic                          s_w_ready_i,
  input  logic [AXI4_ID_WIDTH-1:0]      s_b_id_i,
  input  logic [1:0]                    s_b_resp_i,
  input  logic                          s_b_valid_i,
  output logic                          s_b_ready_o,
  output logic                          grant_o,
  output logic                          busy_o,
  output logic                          err_o
);
  state_e     state_q, state_d;
  logic       grant_q, grant_d;
  logic [7:0] len_q, len_d;
  logic [7:0] beat_q, beat_d;
  logic       err_q, err_d;
  logic       arb_grant;

  logic st_addr, st_data, st_resp;
  logic g_aw_valid, g_w_valid, g_w_last, g_b_ready;
  logic beat_last, aw_hs, w_hs, b_hs;

  assign st_addr = (state_q == ADDR);
  assign st_data = (state_q == DATA);
  assign st_resp = (state_q == RESP);

  assign g_aw_valid = grant_q ? m1_aw_valid_i : m0_aw_valid_i;
  assign g_w_valid  = grant_q ? m1_w_valid_i  : m0_w_valid_i;
  assign g_w_last   = grant_q ? m1_w_last_i   : m0_w_last_i;
  assign g_b_ready  = grant_q ? m1_b_ready_i  : m0_b_ready_i;

  assign s_aw_id_o    = grant_q ? m1_aw_id_i   : m0_aw_id_i;
  assign s_aw_addr_o  = grant_q ? m1_aw_addr_i : m0_aw_addr_i;
  assign s_aw_len_o   = grant_q ? m1_aw_len_i  : m0_aw_len_i;
  assign s_aw_valid_o = st_addr & g_aw_valid;

  // Last is driven from the beat count so a misbehaving requester cannot cut a burst short.
  assign beat_last   = (beat_q == len_q);
  assign s_w_data_o  = grant_q ? m1_w_data_i : m0_w_data_i;
  assign s_w_strb_o  = grant_q ? m1_w_strb_i : m0_w_strb_i;
  assign s_w_last_o  = st_data & beat_last;
  assign s_w_valid_o = st_data & g_w_valid;
  assign s_b_ready_o = st_resp & g_b_ready;

  assign m0_aw_ready_o = st_addr & ~grant_q & s_aw_ready_i;
  assign m1_aw_ready_o = st_addr &  grant_q & s_aw_ready_i;
  assign m0_w_ready_o  = st_data & ~grant_q & s_w_ready_i;
  assign m1_w_ready_o  = st_data &  grant_q & s_w_ready_i;
  assign m0_b_valid_o  = st_resp & ~grant_q & s_b_valid_i;
  assign m1_b_valid_o  = st_resp &  grant_q & s_b_valid_i;
  assign m0_b_id_o     = s_b_id_i;
  assign m1_b_id_o     = s_b_id_i;
  assign m0_b_resp_o   = s_b_resp_i;
  assign m1_b_resp_o   = s_b_resp_i;

  assign aw_hs = s_aw_valid_o & s_aw_ready_i;
  assign w_hs  = s_w_valid_o & s_w_ready_i;
  assign b_hs  = st_resp & s_b_valid_i & g_b_ready;

  axi_rr_arb2 u_arb (
    .iclk   (iclk),
    .rst_n  (rst_n),
    .req    ({m1_aw_valid_i, m0_aw_valid_i}),
    .update (b_hs),
    .served (grant_q),
    .grant  (arb_grant)
  );

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    len_d   = len_q;
    beat_d  = beat_q;
    err_d   = err_q;
    unique case (state_q)
      IDLE: if (m0_aw_valid_i | m1_aw_valid_i) begin
        grant_d = arb_grant;
        state_d = ADDR;
      end
      ADDR: if (aw_hs) begin
        len_d   = s_aw_len_o;
        beat_d  = 8'd0;
        state_d = DATA;
      end
      DATA: if (w_hs) begin
        beat_d = beat_q + 8'd1;
        if (g_w_last != beat_last) err_d = 1'b1;
        if (beat_last) state_d = RESP;
      end
      RESP: if (b_hs) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge iclk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      grant_q <= 1'b0;
      len_q   <= 8'd0;
      beat_q  <= 8'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      len_q   <= len_d;
      beat_q  <= beat_d;
      err_q   <= err_d;
    end
  end

  assign grant_o = grant_q;
  assign busy_o  = (state_q != IDLE);
  assign err_o   = err_q;
endmodule

// File: tb/tb_axi_wr_arbiter.sv
// Directed bench: requesters and slave are driven inline; expected AW/W/B items are queued and popped on handshakes.
module tb_axi_wr_arbiter;
  import axi_wr_pkg::*;
  localparam int AW = 32, DW = 32, IW = 16, SW = DW/8;

  logic iclk = 1'b0;
  logic rst_n;
  always #5 iclk = ~iclk;

  logic [IW-1:0] m_aw_id [2];
  logic [AW-1:0] m_aw_addr [2];
  logic [7:0]    m_aw_len [2];
  logic [1:0]    m_aw_valid, m_aw_ready;
  logic [DW-1:0] m_w_data [2];
  logic [SW-1:0] m_w_strb [2];
  logic [1:0]    m_w_last, m_w_valid, m_w_ready;
  logic [IW-1:0] m_b_id [2];
  logic [1:0]    m_b_resp [2];
  logic [1:0]    m_b_valid, m_b_ready;

  logic [IW-1:0] s_aw_id;  logic [AW-1:0] s_aw_addr; logic [7:0] s_aw_len;
  logic s_aw_valid, s_aw_ready;
  logic [DW-1:0] s_w_data; logic [SW-1:0] s_w_strb;
  logic s_w_last, s_w_valid, s_w_ready;
  logic [IW-1:0] s_b_id; logic [1:0] s_b_resp; logic s_b_valid, s_b_ready;
  logic grant_o, busy_o, err_o;

  axi_wr_arbiter #(.AXI4_ADDRESS_WIDTH(AW), .AXI4_WDATA_WIDTH(DW), .AXI4_ID_WIDTH(IW)) dut (
    .iclk(iclk), .rst_n(rst_n),
    .m0_aw_id_i(m_aw_id[0]), .m0_aw_addr_i(m_aw_addr[0]), .m0_aw_len_i(m_aw_len[0]),
    .m0_aw_valid_i(m_aw_valid[0]), .m0_aw_ready_o(m_aw_ready[0]),
    .m0_w_data_i(m_w_data[0]), .m0_w_strb_i(m_w_strb[0]), .m0_w_last_i(m_w_last[0]),
    .m0_w_valid_i(m_w_valid[0]), .m0_w_ready_o(m_w_ready[0]),
    .m0_b_id_o(m_b_id[0]), .m0_b_resp_o(m_b_resp[0]), .m0_b_valid_o(m_b_valid[0]),
    .m0_b_ready_i(m_b_ready[0]),
    .m1_aw_id_i(m_aw_id[1]), .m1_aw_addr_i(m_aw_addr[1]), .m1_aw_len_i(m_aw_len[1]),
    .m1_aw_valid_i(m_aw_valid[1]), .m1_aw_ready_o(m_aw_ready[1]),
    .m1_w_data_i(m_w_data[1]), .m1_w_strb_i(m_w_strb[1]), .m1_w_last_i(m_w_last[1]),
    .m1_w_valid_i(m_w_valid[1]), .m1_w_ready_o(m_w_ready[1]),
    .m1_b_id_o(m_b_id[1]), .m1_b_resp_o(m_b_resp[1]), .m1_b_valid_o(m_b_valid[1]),
    .m1_b_ready_i(m_b_ready[1]),
    .s_aw_id_o(s_aw_id), .s_aw_addr_o(s_aw_addr), .s_aw_len_o(s_aw_len),
    .s_aw_valid_o(s_aw_valid), .s_aw_ready_i(s_aw_ready),
    .s_w_data_o(s_w_data), .s_w_strb_o(s_w_strb), .s_w_last_o(s_w_last),
    .s_w_valid_o(s_w_valid), .s_w_ready_i(s_w_ready),
    .s_b_id_i(s_b_id), .s_b_resp_i(s_b_resp), .s_b_valid_i(s_b_valid), .s_b_ready_o(s_b_ready),
    .grant_o(grant_o), .busy_o(busy_o), .err_o(err_o)
  );

  typedef struct packed {logic [IW-1:0] id; logic [AW-1:0] addr; logic [7:0] len;} aw_t;
  typedef struct packed {logic [DW-1:0] data; logic [SW-1:0] strb; logic last;} w_t;
  aw_t           aw_q [$];
  w_t            w_q [$];
  logic [IW-1:0] b_q [$];
  int checks = 0, failures = 0;
  bit err_m = 1'b0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_aw(input bit who, input logic [IW-1:0] id, input logic [AW-1:0] addr, input logic [7:0] len);
    m_aw_id[who] = id; m_aw_addr[who] = addr; m_aw_len[who] = len; m_aw_valid[who] = 1'b1;
  endtask

  // Runs one burst for the expected winner; caller has raised aw_valid at the preceding negedge.
  task automatic do_xfer(input bit who, input logic [IW-1:0] id, input logic [AW-1:0] addr,
                         input int len, input int err_beat, input int stall, input int rst_beat);
    aw_t e_aw; w_t e_w, o_w; logic [IW-1:0] e_id;
    logic [1:0] sel;
    sel = who ? 2'b10 : 2'b01;
    e_aw.id = id; e_aw.addr = addr; e_aw.len = len[7:0];
    aw_q.push_back(e_aw);
    b_q.push_back(id);
    @(negedge iclk);
    m_w_valid[who] = 1'b1; m_w_data[who] = '0; m_w_last[who] = 1'b0;
    #1;
    chk("grant_busy", {busy_o, grant_o}, {1'b1, who});
    chk("aw_valid_fwd", s_aw_valid, 1);
    chk("early_w_blocked", {m_w_ready, s_w_valid}, 0);
    chk("aw_ready_wait", m_aw_ready, 0);
    for (int i = 0; i < stall; i++) begin
      @(negedge iclk); #1;
      chk("aw_hold", {s_aw_valid, s_aw_id, s_aw_addr, s_aw_len}, {1'b1, aw_q[0]});
      chk("aw_ready_stall", m_aw_ready, 0);
    end
    s_aw_ready = 1'b1; #1;
    chk("aw_ready_route", m_aw_ready, sel);
    e_aw = aw_q.pop_front();
    chk("aw_fields", {s_aw_id, s_aw_addr, s_aw_len}, e_aw);
    @(negedge iclk);
    m_aw_valid[who] = 1'b0; s_aw_ready = 1'b0;
    for (int b = 0; b <= len; b++) begin
      e_w.data = $urandom; e_w.strb = SW'($urandom); e_w.last = (b == len);
      m_w_data[who] = e_w.data; m_w_strb[who] = e_w.strb;
      m_w_last[who] = (b == len) ^ (b == err_beat); m_w_valid[who] = 1'b1;
      w_q.push_back(e_w);
      if (b == rst_beat) begin
        rst_n = 1'b0; s_w_ready = 1'b1;
        @(negedge iclk);
        rst_n = 1'b1; s_w_ready = 1'b0; m_w_valid = '0; m_aw_valid = '0; m_b_ready = '0;
        #1;
        chk("rst_idle", {busy_o, grant_o, err_o}, 0);
        chk("rst_valids", {s_aw_valid, s_w_valid, s_b_ready, m_aw_ready, m_w_ready, m_b_valid}, 0);
        w_q.delete(); b_q.delete(); err_m = 1'b0;
        return;
      end
      if (b == 0) begin
        for (int i = 0; i < stall; i++) begin
          #1;
          chk("w_stall", {m_w_ready, s_w_valid, s_w_data}, {2'b00, 1'b1, e_w.data});
          @(negedge iclk);
        end
      end
      s_w_ready = 1'b1; #1;
      chk("w_ready_route", m_w_ready, sel);
      o_w = {s_w_data, s_w_strb, s_w_last};
      e_w = w_q.pop_front();
      chk("w_beat", {s_w_valid, o_w}, {1'b1, e_w});
      @(negedge iclk);
      s_w_ready = 1'b0;
      if (b == err_beat) begin
        err_m = 1'b1; #1;
        chk("err_set", err_o, 1);
      end
    end
    m_w_valid[who] = 1'b0; m_w_last[who] = 1'b0;
    #1;
    chk("err_sticky", err_o, err_m);
    chk("resp_state", {busy_o, s_w_valid}, 2'b10);
    m_b_ready[who] = 1'b1;
    for (int i = 0; i < stall; i++) begin
      #1;
      chk("b_stall", {m_b_valid, s_b_ready}, 3'b001);
      @(negedge iclk);
    end
    s_b_valid = 1'b1; s_b_id = id; s_b_resp = RESP_OKAY; #1;
    e_id = b_q.pop_front();
    chk("b_route", {m_b_valid, s_b_ready}, {sel, 1'b1});
    chk("b_id", {m_b_id[who], m_b_resp[who]}, {e_id, RESP_OKAY});
    @(negedge iclk);
    s_b_valid = 1'b0; m_b_ready[who] = 1'b0; #1;
    chk("idle_after_b", busy_o, 0);
  endtask

  initial begin
    rst_n = 1'b0;
    for (int k = 0; k < 2; k++) begin
      m_aw_id[k] = '0; m_aw_addr[k] = '0; m_aw_len[k] = '0;
      m_w_data[k] = '0; m_w_strb[k] = '0;
    end
    m_aw_valid = '0; m_w_last = '0; m_w_valid = '0; m_b_ready = '0;
    s_aw_ready = 1'b0; s_w_ready = 1'b0; s_b_id = '0; s_b_resp = '0; s_b_valid = 1'b0;
    repeat (3) @(negedge iclk);
    #1;
    chk("reset_state", {busy_o, grant_o, err_o}, 0);
    // Idle gating: slave handshakes and requester W/B signals must not leak through.
    s_aw_ready = 1'b1; s_w_ready = 1'b1; s_b_valid = 1'b1; m_w_valid = 2'b11; m_b_ready = 2'b11;
    rst_n = 1'b1;
    @(negedge iclk); #1;
    chk("idle_gating", {busy_o, s_aw_valid, s_w_valid, s_b_ready, m_aw_ready, m_w_ready, m_b_valid}, 0);
    s_aw_ready = 1'b0; s_w_ready = 1'b0; s_b_valid = 1'b0; m_w_valid = '0; m_b_ready = '0;

    @(negedge iclk);
    set_aw(0, 16'h0011, 32'h3000, 8'd1); set_aw(1, 16'h0022, 32'h4000, 8'd2);
    do_xfer(0, 16'h0011, 32'h3000, 1, -1, 0, -1);
    do_xfer(1, 16'h0022, 32'h4000, 2, -1, 0, -1);
    @(negedge iclk);
    set_aw(0, 16'h0111, 32'h3100, 8'd2); set_aw(1, 16'h0122, 32'h4100, 8'd1);
    do_xfer(0, 16'h0111, 32'h3100, 2, -1, 0, -1);
    do_xfer(1, 16'h0122, 32'h4100, 1, -1, 0, -1);

    @(negedge iclk); set_aw(0, 16'h0033, 32'h1000, 8'd3);
    do_xfer(0, 16'h0033, 32'h1000, 3, -1, 0, -1);
    @(negedge iclk); set_aw(1, 16'h0044, 32'h2000, 8'd0);
    do_xfer(1, 16'h0044, 32'h2000, 0, -1, 0, -1);
    @(negedge iclk); set_aw(0, 16'h0055, 32'h1100, 8'd3);
    do_xfer(0, 16'h0055, 32'h1100, 3, 1, 0, -1);
    @(negedge iclk); set_aw(1, 16'h0066, 32'h5000, 8'd2);
    do_xfer(1, 16'h0066, 32'h5000, 2, -1, 5, -1);
    @(negedge iclk); set_aw(0, 16'h0077, 32'h6000, 8'd3);
    do_xfer(0, 16'h0077, 32'h6000, 3, -1, 0, 2);
    @(negedge iclk); set_aw(1, 16'h0088, 32'h7000, 8'd1);
    do_xfer(1, 16'h0088, 32'h7000, 1, -1, 0, -1);
    @(negedge iclk); set_aw(0, 16'h0099, 32'h8000, 8'd255);
    do_xfer(0, 16'h0099, 32'h8000, 255, -1, 0, -1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
